// File: rtl/mem_access_unit.sv
// Load/store unit between a simple request/response port and a single-cycle
// word-addressed data memory; sub-word stores are done as read-modify-write.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_adr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_WrEn,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid and its payload hold steady until that edge.
   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  sgn_q, sgn_d;
   logic [1:0]            off_q, off_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] mem_adr_q, mem_adr_d;
   logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;

   logic                  misaligned;
   logic [4:0]            byte_sh, half_sh;
   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [DATA_WIDTH-1:0] load_ext, store_merge;

   // Big-endian lanes: offset 0 is the most significant byte of the word.
   always_comb begin
      misaligned  = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      byte_sh     = {~off_q, 3'b000};
      half_sh     = {~off_q[1], 4'b0000};
      byte_lane   = mem_data_out[byte_sh +: 8];
      half_lane   = mem_data_out[half_sh +: 16];
      case (size_q)
         2'b00:   load_ext = {{(DATA_WIDTH-8){sgn_q & byte_lane[7]}}, byte_lane};
         2'b01:   load_ext = {{(DATA_WIDTH-16){sgn_q & half_lane[15]}}, half_lane};
         default: load_ext = mem_data_out;
      endcase
      store_merge = mem_data_out;
      if (size_q == 2'b00) store_merge[byte_sh +: 8]  = wdata_q[7:0];
      else                 store_merge[half_sh +: 16] = wdata_q;
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      size_d        = size_q;
      sgn_d         = sgn_q;
      off_d         = off_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      mem_adr_d     = mem_adr_q;
      mem_data_in_d = mem_data_in_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               sgn_d   = req_signed;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata[15:0];
               rdata_d = '0;
               err_d   = misaligned;
               if (misaligned) begin
                  state_d = RESP;
               end else begin
                  mem_adr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  if (req_we && req_size == 2'b10) begin
                     mem_data_in_d = req_wdata;
                     state_d       = WR;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            if (we_q) begin
               mem_data_in_d = store_merge;
               state_d       = WR;
            end else begin
               rdata_d = load_ext;
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         default: if (resp_ready) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         size_q        <= 2'b00;
         sgn_q         <= 1'b0;
         off_q         <= 2'b00;
         wdata_q       <= '0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         mem_adr_q     <= '0;
         mem_data_in_q <= '0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         size_q        <= size_d;
         sgn_q         <= sgn_d;
         off_q         <= off_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
         mem_adr_q     <= mem_adr_d;
         mem_data_in_q <= mem_data_in_d;
      end
   end

   // Decoded from state so an asynchronous reset kills a write pulse at once.
   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign mem_WrEn    = (state_q == WR);
   assign resp_rdata  = rdata_q;
   assign resp_err    = err_q;
   assign mem_adr     = mem_adr_q;
   assign mem_data_in = mem_data_in_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table through a scoreboard, plus
// back-pressure and reset-during-write sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_WrEn;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata, mem_adr, mem_data_in, mem_data_out;
   logic [1:0]  dbg_state;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_adr(mem_adr),
      .mem_data_in(mem_data_in), .mem_WrEn(mem_WrEn),
      .mem_data_out(mem_data_out), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write sampled mid-cycle.
   logic [31:0] mem [0:255];
   int          wr_cnt = 0;
   logic [31:0] wr_adr = '0, wr_data = '0;
   assign mem_data_out = mem[mem_adr[9:2]];
   always @(negedge clk) begin
      if (mem_WrEn) begin
         wr_cnt  = wr_cnt + 1;
         wr_adr  = mem_adr;
         wr_data = mem_data_in;
         mem[mem_adr[9:2]] = mem_data_in;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic        exp_wr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t        vecs [15];
   logic [32:0] exp_q [$];
   int          tests = 0;
   int          fails = 0;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] init, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat,
                               input logic exp_wr, input logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.init = init; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      v.exp_lat = exp_lat; v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the DUT idle.
   task automatic run_txn(input vec_t v, input string tag, input int hold);
      logic [32:0] exp;
      logic [31:0] held;
      int          lat;
      mem[v.addr[9:2]] = v.init;
      wr_cnt = 0;
      chk({tag, "_idle_ready"}, 33'(req_ready), 33'd1);
      exp_q.push_back({v.exp_err, v.exp_rdata});
      resp_ready = (hold == 0);
      req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 33'(lat), 33'(v.exp_lat));
      exp = exp_q.pop_front();
      chk({tag, "_resp"}, {resp_err, resp_rdata}, exp);
      held = resp_rdata;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, 33'(resp_valid), 33'd1);
         chk({tag, "_hold_rdata"}, 33'(resp_rdata), 33'(held));
         chk({tag, "_hold_ready"}, 33'(req_ready), 33'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_done_valid"}, 33'(resp_valid), 33'd0);
      chk({tag, "_done_ready"}, 33'(req_ready), 33'd1);
      chk({tag, "_wr_cnt"}, 33'(wr_cnt), v.exp_wr ? 33'd1 : 33'd0);
      if (v.exp_wr) begin
         chk({tag, "_wr_adr"}, 33'(wr_adr), 33'({v.addr[31:2], 2'b00}));
         chk({tag, "_wr_data"}, 33'(wr_data), 33'(v.exp_wdata));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      //            we    size   sgn   addr      wdata         init          rdata         err  lat wr    wdata
      vecs[0]  = mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h11223344, 32'h00000044, 1'b0, 2, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 2'b00, 1'b1, 32'h100, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 1'b0, 2, 1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'h1234ABCD, 32'h0000ABCD, 1'b0, 2, 1'b0, 32'h0);
      vecs[3]  = mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h1234ABCD, 32'hFFFFABCD, 1'b0, 2, 1'b0, 32'h0);
      vecs[4]  = mk(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000EE, 32'h11223344, 32'h0,        1'b0, 3, 1'b1, 32'h11EE3344);
      vecs[5]  = mk(1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 1'b0, 32'h0);
      vecs[6]  = mk(1'b0, 2'b10, 1'b1, 32'h104, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0);
      vecs[7]  = mk(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2, 1'b1, 32'hCAFEF00D);
      vecs[8]  = mk(1'b1, 2'b01, 1'b0, 32'h10E, 32'h1234BEEF, 32'hAABBCCDD, 32'h0,        1'b0, 3, 1'b1, 32'hAABBBEEF);
      vecs[9]  = mk(1'b1, 2'b01, 1'b0, 32'h10C, 32'h1234BEEF, 32'hAABBCCDD, 32'h0,        1'b0, 3, 1'b1, 32'hBEEFCCDD);
      vecs[10] = mk(1'b0, 2'b11, 1'b0, 32'h110, 32'h0,        32'h55555555, 32'h0,        1'b1, 1, 1'b0, 32'h0);
      vecs[11] = mk(1'b0, 2'b01, 1'b1, 32'h111, 32'h0,        32'h55555555, 32'h0,        1'b1, 1, 1'b0, 32'h0);
      vecs[12] = mk(1'b0, 2'b00, 1'b0, 32'h115, 32'h0,        32'h00C30000, 32'h000000C3, 1'b0, 2, 1'b0, 32'h0);
      vecs[13] = mk(1'b0, 2'b00, 1'b1, 32'h115, 32'h0,        32'h00C30000, 32'hFFFFFFC3, 1'b0, 2, 1'b0, 32'h0);
      vecs[14] = mk(1'b1, 2'b10, 1'b0, 32'h11A, 32'h12345678, 32'h0,        32'h0,        1'b1, 1, 1'b0, 32'h0);

      // Reset values while rst_n is held low.
      #12;
      chk("rst_req_ready",   33'(req_ready),   33'd1);
      chk("rst_resp_valid",  33'(resp_valid),  33'd0);
      chk("rst_resp_err",    33'(resp_err),    33'd0);
      chk("rst_mem_wren",    33'(mem_WrEn),    33'd0);
      chk("rst_resp_rdata",  33'(resp_rdata),  33'd0);
      chk("rst_mem_adr",     33'(mem_adr),     33'd0);
      chk("rst_mem_data_in", 33'(mem_data_in), 33'd0);
      chk("rst_state",       33'(dbg_state),   33'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("v%0d", i), 0);

      // Response held off by the consumer for five cycles.
      run_txn(vecs[3], "backpressure", 5);

      // Reset pulse while the word store sits in WR.
      mem[8'h48] = 32'h01020304;
      wr_cnt = 0;
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h120; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("wrrst_in_wr", 33'(mem_WrEn), 33'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("wrrst_wren_drop", 33'(mem_WrEn),  33'd0);
      chk("wrrst_ready",     33'(req_ready), 33'd1);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("wrrst_no_resp", 33'(resp_valid), 33'd0);
         chk("wrrst_idle",    33'(dbg_state),  33'd0);
      end
      chk("wrrst_no_write", 33'(wr_cnt),    33'd0);
      chk("wrrst_mem_kept", 33'(mem[8'h48]), 33'h01020304);

      // Normal traffic resumes after the aborted store.
      run_txn(vecs[4], "after_rst", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $finish;
   end

endmodule
